// File: rtl/sub_pkg.sv
// ---------------------------------------------------------------------------
// sub_pkg
//   Shared definitions for the bit-serial subtractor:
//     state_e - FSM state encoding (IDLE / RUN / DONE)
//     clog2   - ceiling log2 used to size the bit counter (minimum 1 bit)
// ---------------------------------------------------------------------------
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Statically bounded loop so it elaborates as a constant function.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/serial_subtractor_fs.sv
// ---------------------------------------------------------------------------
// full_subtractor
//   One-bit combinational subtractor cell: d = a - b - bin.
//   Ports:
//     a_i    minuend bit
//     b_i    subtrahend bit
//     bin_i  borrow in
//     d_o    difference bit
//     bout_o borrow out
// ---------------------------------------------------------------------------
module full_subtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    assign d_o    = a_i ^ b_i ^ bin_i;
    // Borrow when a<b outright, or when a==b and a borrow is already pending.
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial subtractor: diff = a - b - bin over WIDTH bits, one bit per
//   clock, LSB first. Operands enter on a valid/ready handshake; the result
//   leaves on a valid/ready handshake together with borrow-out and signed
//   overflow.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     in_valid / in_ready   operand handshake (in_ready high only in IDLE)
//     in_a, in_b, in_bin    minuend, subtrahend, borrow in
//     out_valid / out_ready result handshake
//     out_diff              a - b - bin modulo 2^WIDTH
//     out_bout              unsigned borrow out
//     out_ovf               two's-complement overflow
// ---------------------------------------------------------------------------
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_bout,
    output logic             out_ovf
);

    localparam int                CNT_W    = clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q;
    logic [WIDTH-1:0]   a_q, b_q, res_q;
    logic [WIDTH-1:0]   res_d;
    logic               br_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               a_msb_q, b_msb_q;
    logic [WIDTH-1:0]   out_diff_q;
    logic               out_bout_q, out_ovf_q, out_valid_q;

    logic               bit_d, bit_bo;

    full_subtractor u_cell (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .bin_i  (br_q),
        .d_o    (bit_d),
        .bout_o (bit_bo)
    );

    // Result fills from the top so that after WIDTH shifts bit 0 sits at LSB.
    assign res_d = {bit_d, res_q[WIDTH-1:1]};

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_diff  = out_diff_q;
    assign out_bout  = out_bout_q;
    assign out_ovf   = out_ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            br_q        <= 1'b0;
            cnt_q       <= '0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            out_diff_q  <= '0;
            out_bout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        br_q    <= in_bin;
                        // Sign bits are shifted out of a_q/b_q, keep copies.
                        a_msb_q <= in_a[WIDTH-1];
                        b_msb_q <= in_b[WIDTH-1];
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    res_q <= res_d;
                    a_q   <= {1'b0, a_q[WIDTH-1:1]};
                    b_q   <= {1'b0, b_q[WIDTH-1:1]};
                    br_q  <= bit_bo;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        out_diff_q  <= res_d;
                        out_bout_q  <= bit_bo;
                        // Overflow only possible when operand signs differ and
                        // the result sign disagrees with the minuend.
                        out_ovf_q   <= (a_msb_q != b_msb_q) && (bit_d != a_msb_q);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//   Two instances (WIDTH=4 directed, WIDTH=8 random) checked against a plain
//   integer-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=4 instance
    logic       iv4 = 0, ir4, ov4, or4 = 0, bi4 = 0, bo4, of4;
    logic [3:0] a4 = 0, b4 = 0, d4;
    // WIDTH=8 instance
    logic       iv8 = 0, ir8, ov8, or8 = 0, bi8 = 0, bo8, of8;
    logic [7:0] a8 = 0, b8 = 0, d8;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv4), .in_ready(ir4), .in_a(a4), .in_b(b4), .in_bin(bi4),
        .out_valid(ov4), .out_ready(or4), .out_diff(d4), .out_bout(bo4), .out_ovf(of4)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8), .in_bin(bi8),
        .out_valid(ov8), .out_ready(or8), .out_diff(d8), .out_bout(bo8), .out_ovf(of8)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain unsigned and signed integer subtraction.
    task automatic ref_sub(input int w, input int a, input int b, input int bin,
                           output int diff, output bit bout, output bit ovf);
        longint full, sa, sb, sf, half;
        half = longint'(1) << (w - 1);
        full = longint'(a) - longint'(b) - longint'(bin);
        diff = int'(full & ((longint'(1) << w) - 1));
        bout = (full < 0);
        sa   = (a >= half) ? a - 2 * half : a;
        sb   = (b >= half) ? b - 2 * half : b;
        sf   = sa - sb - bin;
        ovf  = (sf < -half) || (sf > half - 1);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=4 operation. hold keeps in_valid high with scrambled operands
    // while the block is busy.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                        input int stall, input bit hold);
        int n, d;
        bit bo, of;
        chk("w4_in_ready_idle", ir4, 1);
        a4 = a; b4 = b; bi4 = bin; iv4 = 1; or4 = (stall == 0);
        tick;
        if (!hold) iv4 = 0;
        n = 0;
        while (!ov4 && n < 20) begin
            if (hold) begin
                a4 = 4'($urandom_range(0, 15));
                b4 = 4'($urandom_range(0, 15));
                bi4 = 1'($urandom_range(0, 1));
                chk("w4_in_ready_busy", ir4, 0);
            end
            tick;
            n++;
        end
        chk("w4_latency", n, 4);
        ref_sub(4, a, b, bin, d, bo, of);
        chk("w4_diff", d4, d);
        chk("w4_bout", bo4, bo);
        chk("w4_ovf", of4, of);
        repeat (stall) begin
            tick;
            chk("w4_stall_valid", ov4, 1);
            chk("w4_stall_ready", ir4, 0);
            chk("w4_stall_diff", d4, d);
            chk("w4_stall_bout", bo4, bo);
            chk("w4_stall_ovf", of4, of);
        end
        or4 = 1;
        tick;
        chk("w4_valid_drop", ov4, 0);
        chk("w4_ready_back", ir4, 1);
        chk("w4_diff_retained", d4, d);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input int stall);
        int n, d;
        bit bo, of;
        chk("w8_in_ready_idle", ir8, 1);
        a8 = a; b8 = b; bi8 = bin; iv8 = 1; or8 = (stall == 0);
        tick;
        iv8 = 0;
        n = 0;
        while (!ov8 && n < 30) begin
            tick;
            n++;
        end
        chk("w8_latency", n, 8);
        ref_sub(8, a, b, bin, d, bo, of);
        repeat (stall) begin
            tick;
            chk("w8_stall_valid", ov8, 1);
        end
        chk("w8_diff", d8, d);
        chk("w8_bout", bo8, bo);
        chk("w8_ovf", of8, of);
        or8 = 1;
        tick;
        chk("w8_valid_drop", ov8, 0);
        or8 = 0;
    endtask

    initial begin
        logic [3:0] na, nb;
        logic       nbin;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_w4_in_ready", ir4, 1);
        chk("rst_w4_out_valid", ov4, 0);
        chk("rst_w4_diff", d4, 0);
        chk("rst_w4_bout", bo4, 0);
        chk("rst_w4_ovf", of4, 0);
        chk("rst_w8_in_ready", ir8, 1);
        chk("rst_w8_out_valid", ov8, 0);
        chk("rst_w8_diff", d8, 0);
        rst_n = 1;
        tick;

        // Directed WIDTH=4 cases (ovf on 9-3, borrow cases, bin with a==b).
        run4(4'd9, 4'd3, 1'b0, 0, 0);
        chk("w4_9m3_ovf_const", of4, 1);
        run4(4'd3, 4'd5, 1'b0, 0, 0);
        chk("w4_3m5_diff_const", d4, 14);
        run4(4'd0, 4'd0, 1'b1, 0, 0);
        chk("w4_0m0m1_diff_const", d4, 15);
        chk("w4_0m0m1_bout_const", bo4, 1);

        // Backpressure: 5 stall cycles.
        run4(4'd12, 4'd4, 1'b0, 5, 0);
        chk("w4_12m4_diff_const", d4, 8);

        // in_valid held high through RUN/DONE with changing operands.
        run4(4'd6, 4'd11, 1'b1, 2, 1);
        na = a4; nb = b4; nbin = bi4;
        run4(na, nb, nbin, 0, 0);

        // Reset mid-RUN discards the operation.
        run4(4'd13, 4'd2, 1'b0, 0, 0);
        a4 = 4'd10; b4 = 4'd1; bi4 = 0; iv4 = 1; or4 = 1;
        tick;
        iv4 = 0;
        tick;
        rst_n = 0;
        #1;
        chk("midrst_out_valid", ov4, 0);
        chk("midrst_in_ready", ir4, 1);
        chk("midrst_diff", d4, 0);
        #2;
        rst_n = 1;
        tick;
        chk("midrst_still_idle", ov4, 0);
        run4(4'd7, 4'd2, 1'b0, 0, 0);
        chk("w4_7m2_diff_const", d4, 5);

        // Random WIDTH=8 sweep with random output stalls.
        for (int i = 0; i < 1000; i++) begin
            run8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
